mipi_csi_rx_packet_decoder_param: RTL and testbench

Parametrised CSI-2 packet decoder for 1, 2 or 4 lanes at 8-bit gear. It takes lane-aligned bytes from the lane aligner at the MIPI byte clock, finds the sync word, and decodes the 4-byte packet header. Accepted long-packet payload is emitted with per-byte enables and a last flag; CRC and trailer are stripped. Short packets (FS/FE/LS/LE) are decoded into strobes for the downstream frame/line builder.

---
 rtl/mipi_csi_rx_packet_decoder_param_if.sv | 35 +++
 rtl/mipi_csi_rx_packet_decoder_param.sv | 172 +++++++++++++++++
 tb/tb_mipi_csi_rx_packet_decoder_param.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_csi_rx_packet_decoder_param_if.sv
// Lane-aligned byte stream in, decoded payload and short-packet strobes out.
// master: lane aligner side (drives bytes), slave: packet decoder side.
interface mipi_csi_rx_packet_decoder_param_if #(
  parameter int LANES = 2
);
  logic                 data_valid_i;
  logic [8*LANES-1:0]   data_i;
  logic                 output_valid_o;
  logic [8*LANES-1:0]   data_o;
  logic [LANES-1:0]     byte_en_o;
  logic                 packet_last_o;
  logic [15:0]          packet_length_o;
  logic [5:0]           packet_type_o;
  logic [1:0]           virtual_channel_o;
  logic                 frame_start_o;
  logic                 frame_end_o;
  logic                 line_start_o;
  logic                 line_end_o;
  logic [15:0]          frame_number_o;
  logic                 ecc_err_o;

  modport master (
    output data_valid_i, data_i,
    input  output_valid_o, data_o, byte_en_o, packet_last_o, packet_length_o,
           packet_type_o, virtual_channel_o, frame_start_o, frame_end_o,
           line_start_o, line_end_o, frame_number_o, ecc_err_o
  );

  modport slave (
    input  data_valid_i, data_i,
    output output_valid_o, data_o, byte_en_o, packet_last_o, packet_length_o,
           packet_type_o, virtual_channel_o, frame_start_o, frame_end_o,
           line_start_o, line_end_o, frame_number_o, ecc_err_o
  );
endinterface

// File: rtl/mipi_csi_rx_packet_decoder_param.sv
// CSI-2 packet decoder for 1/2/4 lanes at 8-bit gear: sync detect, header
// decode, payload forwarding with byte enables, short-packet strobes.
// Optional macro ECC_CHECK_EN: check the header Hamming ECC and drop the
// packet (with an ecc_err_o pulse) on mismatch; otherwise the ECC byte is ignored.
//
// state    | meaning
// IDLE     | waiting for the all-lanes 8'hB8 sync word
// HEADER   | collecting DI/WC_L/WC_H/ECC, decoded on the last header cycle
// PAYLOAD  | forwarding long-packet payload, counting down remaining bytes
// WAIT_END | packet done or dropped, waiting for data_valid_i to fall
module mipi_csi_rx_packet_decoder_param #(
  parameter int          LANES          = 2,
  parameter logic [63:0] DT_ACCEPT_MASK = 64'h0000_3C00_0000_0000,
  parameter logic [3:0]  VC_ACCEPT_MASK = 4'hF
) (
  input logic clk_i,
  input logic reset_n_i,
  mipi_csi_rx_packet_decoder_param_if.slave bus
);
  localparam int          W         = 8 * LANES;
  localparam int          NH        = 4 / LANES;
  localparam logic [1:0]  HDR_LAST  = 2'(NH - 1);
  localparam logic [W-1:0] SYNC_WORD = {LANES{8'hB8}};
  localparam logic [15:0] LANES_W   = 16'(LANES);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
    $error("LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, WAIT_END} state_t;

  state_t      state;
  logic [1:0]  hdr_cnt;
  logic [31:0] hdr_q;
  logic [15:0] remaining;

  logic [31:0]      hdr_now;
  logic [5:0]       hdr_dt;
  logic [1:0]       hdr_vc;
  logic [15:0]      hdr_wc;
  logic             ecc_ok;
  logic             accept_long;
  logic [LANES-1:0] last_en;
  logic             unused_ecc_bits;

  // Full header as seen in the decode cycle: stored bytes plus the current lanes
  always_comb begin
    hdr_now = hdr_q;
    for (int k = 0; k < NH; k++) begin
      if (hdr_cnt == 2'(k)) hdr_now[k*W +: W] = bus.data_i;
    end
    hdr_dt = hdr_now[5:0];
    hdr_vc = hdr_now[7:6];
    hdr_wc = hdr_now[23:8];
    accept_long = DT_ACCEPT_MASK[hdr_dt] && VC_ACCEPT_MASK[hdr_vc] && (hdr_wc != 16'd0);
  end

  assign unused_ecc_bits = ^hdr_now[31:24];

`ifdef ECC_CHECK_EN
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  assign ecc_ok = (calc_ecc(hdr_now[23:0]) == hdr_now[29:24]);
`else
  assign ecc_ok = 1'b1;
`endif

  // Byte enables for the final payload word: one bit per remaining byte
  always_comb begin
    last_en = '0;
    for (int k = 0; k < LANES; k++) last_en[k] = (16'(k) < remaining);
  end

  // Packet FSM with registered payload, header and strobe outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                 <= IDLE;
      hdr_cnt               <= '0;
      hdr_q                 <= '0;
      remaining             <= '0;
      bus.output_valid_o    <= 1'b0;
      bus.data_o            <= '0;
      bus.byte_en_o         <= '0;
      bus.packet_last_o     <= 1'b0;
      bus.packet_length_o   <= '0;
      bus.packet_type_o     <= '0;
      bus.virtual_channel_o <= '0;
      bus.frame_start_o     <= 1'b0;
      bus.frame_end_o       <= 1'b0;
      bus.line_start_o      <= 1'b0;
      bus.line_end_o        <= 1'b0;
      bus.frame_number_o    <= '0;
      bus.ecc_err_o         <= 1'b0;
    end else begin
      bus.output_valid_o <= 1'b0;
      bus.byte_en_o      <= '0;
      bus.packet_last_o  <= 1'b0;
      bus.frame_start_o  <= 1'b0;
      bus.frame_end_o    <= 1'b0;
      bus.line_start_o   <= 1'b0;
      bus.line_end_o     <= 1'b0;
      bus.ecc_err_o      <= 1'b0;
      if (!bus.data_valid_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.data_i == SYNC_WORD) begin
              state   <= HEADER;
              hdr_cnt <= '0;
            end
          end
          HEADER: begin
            if (hdr_cnt != HDR_LAST) begin
              for (int k = 0; k < NH; k++) begin
                if (hdr_cnt == 2'(k)) hdr_q[k*W +: W] <= bus.data_i;
              end
              hdr_cnt <= hdr_cnt + 2'd1;
            end else begin
              state <= WAIT_END;
              if (!ecc_ok) begin
                bus.ecc_err_o <= 1'b1;
              end else if (hdr_dt < 6'h10) begin
                case (hdr_dt)
                  6'h00: begin
                    bus.frame_start_o  <= 1'b1;
                    bus.frame_number_o <= hdr_wc;
                  end
                  6'h01: begin
                    bus.frame_end_o    <= 1'b1;
                    bus.frame_number_o <= hdr_wc;
                  end
                  6'h02:   bus.line_start_o <= 1'b1;
                  6'h03:   bus.line_end_o   <= 1'b1;
                  default: ;
                endcase
              end else if (accept_long) begin
                state                 <= PAYLOAD;
                remaining             <= hdr_wc;
                bus.packet_type_o     <= hdr_dt;
                bus.virtual_channel_o <= hdr_vc;
                bus.packet_length_o   <= hdr_wc;
              end
            end
          end
          PAYLOAD: begin
            bus.output_valid_o <= 1'b1;
            bus.data_o         <= bus.data_i;
            if (remaining > LANES_W) begin
              bus.byte_en_o <= '1;
              remaining     <= remaining - LANES_W;
            end else begin
              bus.byte_en_o     <= last_en;
              bus.packet_last_o <= 1'b1;
              state             <= WAIT_END;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_param.sv
// Scoreboard bench: the driver builds each HS burst as a byte stream, derives
// the expected payload words / strobes from the packet rules and queues them;
// a negedge monitor pops and compares whenever the DUT presents output.
module tb_mipi_csi_rx_packet_decoder_param;
  localparam int          LANES   = 2;
  localparam int          NH      = 4 / LANES;
  localparam int          W       = 8 * LANES;
  localparam logic [63:0] DT_MASK = 64'h0000_3C00_0000_0000;
  localparam logic [3:0]  VC_MASK = 4'b1011;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;
  int   cyc       = 0;
  int   total     = 0;
  int   bad       = 0;
  bit   gap_chk   = 1'b0;

  logic [5:0]  exp_dt   = '0;
  logic [1:0]  exp_vc   = '0;
  logic [15:0] exp_wc   = '0;
  logic [15:0] exp_fnum = '0;

  typedef struct {
    int               cyc;
    logic [W-1:0]     data;
    logic [LANES-1:0] en;
    logic             last;
    logic [5:0]       dt;
    logic [1:0]       vc;
    logic [15:0]      wc;
  } word_t;

  typedef struct {
    int          cyc;
    logic [4:0]  kind;   // {ecc, fs, fe, ls, le}
    logic [15:0] fnum;
  } evt_t;

  word_t q_word[$];
  evt_t  q_evt[$];

  mipi_csi_rx_packet_decoder_param_if #(.LANES(LANES)) bus ();

  mipi_csi_rx_packet_decoder_param #(
    .LANES(LANES),
    .DT_ACCEPT_MASK(DT_MASK),
    .VC_ACCEPT_MASK(VC_MASK)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // CSI-2 header Hamming code: data bits covered by each parity bit (-1 = unused)
  int ecc_tbl [6][14] = '{
    '{0, 1, 2, 4, 5, 7, 10, 11, 13, 16, 20, 21, 22, 23},
    '{0, 1, 3, 4, 6, 8, 10, 12, 14, 17, 20, 21, 22, 23},
    '{0, 2, 3, 5, 6, 9, 11, 12, 15, 18, 20, 21, 22, -1},
    '{1, 2, 3, 7, 8, 9, 13, 14, 15, 19, 20, 21, 23, -1},
    '{4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 22, 23, -1},
    '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 21, 22, 23, -1}};

  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [5:0] p = '0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 14; j++)
        if (ecc_tbl[i][j] >= 0) p[i] = p[i] ^ d[ecc_tbl[i][j]];
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations
  always @(negedge clk_i) begin : mon
    word_t        w;
    evt_t         e;
    logic [W-1:0] m;
    logic [4:0]   k;
    if (!reset_n_i) begin
      chk("reset_data", bus.data_o, '0);
      chk("reset_outputs", {bus.output_valid_o, bus.byte_en_o, bus.packet_last_o,
          bus.packet_length_o, bus.packet_type_o, bus.virtual_channel_o,
          bus.frame_start_o, bus.frame_end_o, bus.line_start_o, bus.line_end_o,
          bus.frame_number_o, bus.ecc_err_o}, '0);
    end else begin
      if (bus.output_valid_o) begin
        chk("word_expected", q_word.size() != 0, 1);
        if (q_word.size() != 0) begin
          w = q_word.pop_front();
          for (int i = 0; i < LANES; i++) m[8*i +: 8] = {8{w.en[i]}};
          chk("word_cycle", cyc, w.cyc);
          chk("word_data", bus.data_o & m, w.data & m);
          chk("word_byte_en", bus.byte_en_o, w.en);
          chk("word_last", bus.packet_last_o, w.last);
          chk("word_header", {bus.packet_type_o, bus.virtual_channel_o, bus.packet_length_o},
              {w.dt, w.vc, w.wc});
        end
      end else begin
        chk("idle_en_last", {bus.byte_en_o, bus.packet_last_o}, '0);
      end
      k = {bus.ecc_err_o, bus.frame_start_o, bus.frame_end_o, bus.line_start_o, bus.line_end_o};
      if (k != 5'b0) begin
        chk("event_expected", q_evt.size() != 0, 1);
        if (q_evt.size() != 0) begin
          e = q_evt.pop_front();
          chk("event_kind", k, e.kind);
          chk("event_cycle", cyc, e.cyc);
          if (e.kind[3] | e.kind[2]) chk("frame_number", bus.frame_number_o, e.fnum);
        end
      end
      if (gap_chk) begin
        chk("words_drained", q_word.size(), 0);
        chk("events_drained", q_evt.size(), 0);
        chk("header_hold", {bus.packet_type_o, bus.virtual_channel_o, bus.packet_length_o},
            {exp_dt, exp_vc, exp_wc});
        chk("frame_number_hold", bus.frame_number_o, exp_fnum);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One HS burst: optional idle garbage, sync, header, payload, CRC, padding.
  // trunc>0 stops the burst after that many words; rst_cut ends it with reset.
  task automatic send(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                      input bit corrupt, input int trunc, input int garbage, input bit rst_cut);
    logic [7:0]       s[$];
    logic [15:0]      wc_tx;
    logic [5:0]       ecc;
    logic [W-1:0]     word;
    logic [4:0]       kind;
    bit               ecc_bad, is_long, take;
    int               nw, n_exp, np, p, n;
    ecc   = ref_ecc({wc, vc, dt});
    wc_tx = corrupt ? (wc ^ (16'd1 << $urandom_range(5, 0))) : wc;
`ifdef ECC_CHECK_EN
    ecc_bad = corrupt;
`else
    ecc_bad = 1'b0;
`endif
    is_long = (dt >= 6'h10);
    for (int i = 0; i < LANES; i++) s.push_back(8'hB8);
    s.push_back({vc, dt});
    s.push_back(wc_tx[7:0]);
    s.push_back(wc_tx[15:8]);
    s.push_back({2'b00, ecc});
    if (is_long) begin
      for (int i = 0; i < int'(wc_tx); i++) s.push_back(8'($urandom));
      s.push_back(8'($urandom));
      s.push_back(8'($urandom));
    end
    while (s.size() % LANES != 0) s.push_back(8'($urandom));
    nw = s.size() / LANES;
    if (trunc > 0 && trunc < nw) nw = trunc;
    n_exp = rst_cut ? nw - 1 : nw;
    take  = !ecc_bad && is_long && DT_MASK[dt] && VC_MASK[vc] && (wc_tx != 16'd0);
    np    = (int'(wc_tx) + LANES - 1) / LANES;

    for (int g = 0; g < garbage; g++) begin
      word = W'($urandom);
      if (word == {LANES{8'hB8}}) word[0] = ~word[0];
      tick();
      bus.data_valid_i = 1'b1;
      bus.data_i       = word;
    end
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < LANES; i++) word[8*i +: 8] = s[w*LANES + i];
      tick();
      bus.data_valid_i = 1'b1;
      bus.data_i       = word;
      if (w < n_exp) begin
        if (w == NH) begin
          if (ecc_bad) begin
            q_evt.push_back('{cyc + 1, 5'b10000, 16'h0});
          end else if (dt <= 6'h03) begin
            kind = 5'b01000 >> dt;
            q_evt.push_back('{cyc + 1, kind, wc_tx});
            if (dt <= 6'h01) exp_fnum = wc_tx;
          end else if (take) begin
            exp_dt = dt;
            exp_vc = vc;
            exp_wc = wc_tx;
          end
        end else if (take && w > NH && (w - NH - 1) < np) begin
          p = w - NH - 1;
          n = int'(wc_tx) - p * LANES;
          if (n > LANES) n = LANES;
          q_word.push_back('{cyc + 1, word, LANES'((1 << n) - 1), p == np - 1, dt, vc, wc_tx});
        end
      end
    end
    tick();
    bus.data_valid_i = 1'b0;
    bus.data_i       = W'($urandom);
    if (rst_cut) begin
      reset_n_i = 1'b0;
      exp_dt    = '0;
      exp_vc    = '0;
      exp_wc    = '0;
      exp_fnum  = '0;
      tick();
      tick();
      reset_n_i = 1'b1;
    end
    tick();
    gap_chk = 1'b1;
    tick();
    gap_chk = 1'b0;
    repeat ($urandom_range(2, 0)) tick();
  endtask

  initial begin
    logic [1:0]  r_vc;
    logic [5:0]  r_dt;
    logic [15:0] r_wc;
    int          r_tr;
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
    repeat (3) tick();
    reset_n_i = 1'b1;
    tick();
    gap_chk = 1'b1;
    tick();
    gap_chk = 1'b0;

    send(2'd0, 6'h2B, 16'd10, 1'b0, 0, 0, 1'b0);          // RAW10, 5 full words
    send(2'd1, 6'h2C, 16'd7, 1'b0, 0, 1, 1'b0);           // RAW12, short last word
    send(2'd0, 6'h00, 16'h0005, 1'b0, 0, 0, 1'b0);        // FS
    send(2'd0, 6'h01, 16'h0005, 1'b0, 0, 2, 1'b0);        // FE
    send(2'd3, 6'h02, 16'h1234, 1'b0, 0, 0, 1'b0);        // LS
    send(2'd3, 6'h03, 16'hBEEF, 1'b0, 0, 0, 1'b0);        // LE
    send(2'd0, 6'h12, 16'd8, 1'b0, 0, 0, 1'b0);           // DT not accepted
    send(2'd2, 6'h2A, 16'd6, 1'b0, 0, 0, 1'b0);           // VC not accepted
    send(2'd1, 6'h2A, 16'd6, 1'b0, 0, 0, 1'b0);           // RAW8 accepted
    send(2'd0, 6'h2B, 16'd10, 1'b0, 1 + NH + 2, 0, 1'b0); // truncated after 2 words
    send(2'd0, 6'h2B, 16'd10, 1'b0, 0, 0, 1'b0);
    send(2'd0, 6'h05, 16'd3, 1'b0, 0, 0, 1'b0);           // reserved short type
    send(2'd3, 6'h2D, 16'd0, 1'b0, 0, 0, 1'b0);           // WC=0 long dropped
    send(2'd3, 6'h2D, 16'd1, 1'b0, 0, 0, 1'b0);
    send(2'd0, 6'h2B, 16'd12, 1'b1, 0, 0, 1'b0);          // flipped WC bit
    send(2'd0, 6'h2B, 16'd10, 1'b0, 1 + NH + 3, 0, 1'b1); // reset mid-payload
    send(2'd0, 6'h2A, 16'd9, 1'b0, 0, 0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      r_vc = 2'($urandom);
      case ($urandom_range(3, 0))
        0:       r_dt = 6'($urandom_range(3, 0));
        1:       r_dt = 6'($urandom);
        default: r_dt = 6'($urandom_range(6'h2D, 6'h2A));
      endcase
      r_wc = (r_dt < 6'h10) ? 16'($urandom) : 16'($urandom_range(40, 0));
      r_tr = ($urandom_range(5, 0) == 0) ? $urandom_range(1 + NH + 1 + int'(r_wc) / LANES, 1) : 0;
      send(r_vc, r_dt, r_wc, $urandom_range(7, 0) == 0, r_tr, $urandom_range(2, 0), 1'b0);
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
